// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// 8N1 UART transmitter fed by a small byte FIFO. Bytes written with tx_flag
// are queued and sent back-to-back, LSB first, with BAUD_CNT sclk cycles per
// serial bit. Bit timing matches the companion uart_rx receiver.
//
// Ports:
//   sclk      in   system clock, rising edge
//   srst      in   asynchronous active-high reset (abandons any frame)
//   tx_data   in   [7:0] byte to queue, sampled when tx_flag=1
//   tx_flag   in   one-cycle write strobe
//   fifo_full out  high while the FIFO holds FIFO_DEPTH bytes (registered)
//   ovf       out  one-cycle pulse after a write dropped on a full FIFO
//   tx        out  serial line, idle high, driven from a flop
//   tx_busy   out  high while a frame is on the line
//   tx_done   out  one-cycle pulse on the last cycle of each stop bit
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int BAUD_CNT   = 56,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       sclk,
  input  logic       srst,
  input  logic [7:0] tx_data,
  input  logic       tx_flag,
  output logic       fifo_full,
  output logic       ovf,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BAUD_CNT);

  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_CNT - 1);
  // tx_done is registered, so it is launched one cycle before the last one
  localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_CNT - 2);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;

  // Transmit FSM state
  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          wr_en;
  logic          pop;
  logic          fifo_empty;
  logic          baud_end;
  logic [7:0]    head_byte;

  assign head_byte  = mem_q[rd_ptr_q];
  assign fifo_empty = (cnt_q == {CW{1'b0}});
  assign baud_end   = (baud_q == BAUD_LAST);

  // Write acceptance uses the count before the edge: a same-edge pop never
  // makes room for the incoming byte.
  always_comb begin
    wr_en = 1'b0;
    ovf_d = 1'b0;
    if (tx_flag) begin
      if (cnt_q != DEPTH_C) begin
        wr_en = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else begin
      wr_en = 1'b0;
    end
  end

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d  = cnt_q + CW'(wr_en) - CW'(pop);
    full_d = (cnt_d == DEPTH_C);
  end

  // Frame sequencing: IDLE -> START -> DATA x8 -> STOP -> (START | IDLE)
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = {BW{1'b0}};
        bit_d  = 3'd0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = head_byte;
          state_d = ST_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else begin
          tx_d   = 1'b1;
          busy_d = 1'b0;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_d  = {BW{1'b0}};
          bit_d   = 3'd0;
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_d = {BW{1'b0}};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_d = {BW{1'b0}};
          bit_d  = 3'd0;
          // Chain straight into the next start bit when data is waiting
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head_byte;
            state_d = ST_START;
            tx_d    = 1'b0;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          baud_d = baud_q + BW'(1);
          done_d = (baud_q == BAUD_PRE);
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = {BW{1'b0}};
        bit_d   = 3'd0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FIFO storage; cleared on reset so stale bytes never reappear
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
  end

  // FIFO control registers
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // Transmit FSM registers; tx resets high so an abandoned frame never glitches low
  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      state_q <= ST_IDLE;
      baud_q  <= {BW{1'b0}};
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_full = full_q;
  assign ovf       = ovf_q;
  assign tx        = tx_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int BAUD  = 56;
  localparam int FRAME = 10 * BAUD;

  logic       sclk = 1'b0;
  logic       srst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_flag = 1'b0;
  logic       fifo_full, ovf, tx, tx_busy, tx_done;

  logic [7:0] b_data = 8'h00;
  logic       b_flag = 1'b0;
  logic       b_full, b_ovf, b_tx, b_busy, b_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [8:0] sb_q [$];
  bit         mon_en = 1'b1;
  int         frames_rx = 0;

  bit stat_en = 1'b0;
  int cyc = 0;
  int busy_first = -1;
  int busy_last = -1;
  int busy_cnt = 0;
  int done_cnt = 0;

  logic [7:0] lb_bytes [4] = '{8'h12, 8'h34, 8'hAB, 8'hFF};

  uart_tx_fifo #(.BAUD_CNT(56), .FIFO_DEPTH(4)) u_dut (
    .sclk(sclk), .srst(srst), .tx_data(tx_data), .tx_flag(tx_flag),
    .fifo_full(fifo_full), .ovf(ovf), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_fifo #(.BAUD_CNT(2), .FIFO_DEPTH(2)) u_dut_b (
    .sclk(sclk), .srst(srst), .tx_data(b_data), .tx_flag(b_flag),
    .fifo_full(b_full), .ovf(b_ovf), .tx(b_tx), .tx_busy(b_busy), .tx_done(b_done)
  );

  always #5 sclk = ~sclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Cycle index and busy/done statistics
  initial begin
    forever begin
      @(posedge sclk);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge sclk);
      if (stat_en) begin
        if (tx_busy === 1'b1) begin
          if (busy_first < 0) busy_first = cyc;
          busy_last = cyc;
          busy_cnt++;
        end
        if (tx_done === 1'b1) done_cnt++;
      end
    end
  end

  // Serial receiver model: samples mid-bit and checks against the scoreboard
  initial begin
    logic       prev;
    logic [7:0] got;
    logic [8:0] exp;
    prev = 1'b1;
    forever begin
      @(negedge sclk);
      if (mon_en && prev === 1'b1 && tx === 1'b0) begin
        repeat (BAUD / 2) @(negedge sclk);
        check_eq("rx_start_bit", tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge sclk);
          got[i] = tx;
        end
        repeat (BAUD) @(negedge sclk);
        check_eq("rx_stop_bit", tx, 1'b1);
        if (sb_q.size() > 0) exp = sb_q.pop_front();
        else exp = 9'h1FF;
        check_eq("rx_data", {1'b0, got}, exp);
        frames_rx++;
      end
      prev = tx;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1);
  end

  task automatic wait_idle_a(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < max_cyc) begin
      @(negedge sclk);
      n++;
    end
    check_eq(tag, (n < max_cyc), 1'b1);
    @(posedge sclk); #1;
  endtask

  initial begin
    logic [9:0] fr;
    int n;
    int lows;
    int highs;

    // Reset state
    #97;
    check_eq("rst_tx", tx, 1'b1);
    check_eq("rst_busy", tx_busy, 1'b0);
    check_eq("rst_done", tx_done, 1'b0);
    check_eq("rst_ovf", ovf, 1'b0);
    check_eq("rst_full", fifo_full, 1'b0);
    check_eq("rst_b_tx", b_tx, 1'b1);
    check_eq("rst_b_full", b_full, 1'b0);
    @(posedge sclk); #1;
    srst = 1'b0;
    repeat (2) @(posedge sclk);
    #1;

    // Single byte 0x55 with cycle-exact line check
    tx_flag = 1'b1; tx_data = 8'h55; sb_q.push_back(9'h055);
    @(posedge sclk); #1;
    tx_flag = 1'b0;
    check_eq("t1_tx_before_pop", tx, 1'b1);
    @(posedge sclk); #1;
    check_eq("t1_tx_fall", tx, 1'b0);
    check_eq("t1_busy_rise", tx_busy, 1'b1);
    fr = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < FRAME; j++) begin
      @(negedge sclk);
      check_eq($sformatf("t1_line_c%0d", j), tx, fr[j / BAUD]);
      check_eq($sformatf("t1_done_c%0d", j), tx_done, (j == FRAME - 1));
    end
    @(negedge sclk);
    check_eq("t1_busy_drop", tx_busy, 1'b0);
    check_eq("t1_done_end", tx_done, 1'b0);
    check_eq("t1_tx_idle", tx, 1'b1);
    @(posedge sclk); #1;

    // Four back-to-back frames
    busy_first = -1; busy_last = -1; busy_cnt = 0; done_cnt = 0;
    stat_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_flag = 1'b1; tx_data = lb_bytes[i]; sb_q.push_back({1'b0, lb_bytes[i]});
      @(posedge sclk); #1;
    end
    tx_flag = 1'b0;
    wait_idle_a("t2_idle_wait", 4 * FRAME + 100);
    stat_en = 1'b0;
    check_eq("t2_busy_span", busy_last - busy_first + 1, 4 * FRAME);
    check_eq("t2_busy_cycles", busy_cnt, 4 * FRAME);
    check_eq("t2_done_count", done_cnt, 4);

    // Overflow: six writes, the sixth is dropped
    for (int i = 0; i < 6; i++) begin
      tx_flag = 1'b1; tx_data = 8'(8'hA0 + i);
      if (i < 5) sb_q.push_back({1'b0, 8'(8'hA0 + i)});
      @(posedge sclk); #1;
      if (i == 3) check_eq("t3_full_k3", fifo_full, 1'b0);
      if (i == 4) begin
        check_eq("t3_full_k4", fifo_full, 1'b1);
        check_eq("t3_ovf_k4", ovf, 1'b0);
      end
      if (i == 5) check_eq("t3_ovf_k5", ovf, 1'b1);
    end
    tx_flag = 1'b0;
    @(posedge sclk); #1;
    check_eq("t3_ovf_k6", ovf, 1'b0);
    check_eq("t3_full_k6", fifo_full, 1'b1);
    wait_idle_a("t3_idle_wait", 5 * FRAME + 100);

    // Full FIFO, write on the same edge a stop bit ends and a pop happens
    for (int i = 0; i < 5; i++) begin
      tx_flag = 1'b1; tx_data = 8'(8'hC0 + i); sb_q.push_back({1'b0, 8'(8'hC0 + i)});
      @(posedge sclk); #1;
    end
    tx_flag = 1'b0;
    check_eq("t4_full_set", fifo_full, 1'b1);
    n = 0;
    while (tx_done !== 1'b1 && n < FRAME + 100) begin
      @(negedge sclk);
      n++;
    end
    check_eq("t4_done_wait", (n < FRAME + 100), 1'b1);
    tx_flag = 1'b1; tx_data = 8'hEE;
    @(posedge sclk); #1;
    tx_flag = 1'b0;
    check_eq("t4_ovf", ovf, 1'b1);
    check_eq("t4_full_after_pop", fifo_full, 1'b0);
    check_eq("t4_busy_chain", tx_busy, 1'b1);
    check_eq("t4_tx_next_start", tx, 1'b0);
    tx_flag = 1'b1; tx_data = 8'hE1; sb_q.push_back(9'h0E1);
    @(posedge sclk); #1;
    tx_flag = 1'b0;
    check_eq("t4_refill_full", fifo_full, 1'b1);
    check_eq("t4_refill_ovf", ovf, 1'b0);
    wait_idle_a("t4_idle_wait", 6 * FRAME + 100);

    // Reset during DATA bit 3 of 0x00
    mon_en = 1'b0;
    tx_flag = 1'b1; tx_data = 8'h00;
    @(posedge sclk); #1;
    tx_flag = 1'b0;
    repeat (249) @(posedge sclk);
    #2;
    check_eq("t5_tx_low_before", tx, 1'b0);
    check_eq("t5_busy_before", tx_busy, 1'b1);
    srst = 1'b1;
    #1;
    check_eq("t5_tx_async", tx, 1'b1);
    check_eq("t5_busy_async", tx_busy, 1'b0);
    check_eq("t5_full_async", fifo_full, 1'b0);
    check_eq("t5_done_async", tx_done, 1'b0);
    repeat (3) @(posedge sclk);
    #1;
    srst = 1'b0;
    lows = 0; highs = 0;
    for (int j = 0; j < 700; j++) begin
      @(negedge sclk);
      if (tx !== 1'b1) lows++;
      if (tx_busy !== 1'b0) highs++;
    end
    check_eq("t5_tx_stays_high", lows, 0);
    check_eq("t5_busy_stays_low", highs, 0);

    // Small configuration: BAUD_CNT=2, FIFO_DEPTH=2
    @(posedge sclk); #1;
    b_flag = 1'b1; b_data = 8'h81;
    @(posedge sclk); #1;
    b_flag = 1'b0;
    check_eq("t6_tx_before_pop", b_tx, 1'b1);
    @(posedge sclk); #1;
    check_eq("t6_tx_fall", b_tx, 1'b0);
    fr = {1'b1, 8'h81, 1'b0};
    for (int j = 0; j < 20; j++) begin
      @(negedge sclk);
      check_eq($sformatf("t6_line_c%0d", j), b_tx, fr[j / 2]);
      check_eq($sformatf("t6_done_c%0d", j), b_done, (j == 19));
    end
    @(negedge sclk);
    check_eq("t6_busy_drop", b_busy, 1'b0);
    @(posedge sclk); #1;
    for (int i = 0; i < 4; i++) begin
      b_flag = 1'b1; b_data = 8'(i + 1);
      @(posedge sclk); #1;
      if (i == 1) check_eq("t6_full_k1", b_full, 1'b0);
      if (i == 2) begin
        check_eq("t6_full_k2", b_full, 1'b1);
        check_eq("t6_ovf_k2", b_ovf, 1'b0);
      end
      if (i == 3) check_eq("t6_ovf_k3", b_ovf, 1'b1);
    end
    b_flag = 1'b0;
    @(posedge sclk); #1;
    check_eq("t6_ovf_k4", b_ovf, 1'b0);
    n = 0;
    while (b_busy !== 1'b0 && n < 200) begin
      @(negedge sclk);
      n++;
    end
    check_eq("t6_idle_wait", (n < 200), 1'b1);

    check_eq("sb_left", sb_q.size(), 0);
    check_eq("frames_rx", frames_rx, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
